// File: rtl/sc_test_sequencer_if.sv
// ============================================================================
// Module   : sc_test_sequencer_if
// Purpose  : Bundle of config, memory and register-file access, and status
//            signals between the test sequencer (slave) and its environment
//            (master).
// Options  : SEQ_WATCH_EN adds watch_data / watch_chg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sc_test_sequencer_if #(
  parameter int DATA_W   = 32,
  parameter int MEM_AW   = 8,
  parameter int REG_AW   = 5,
  parameter int NUM_INIT = 8,
  parameter int NUM_CHK  = 8,
  parameter int CYC_W    = 16
);
  localparam int MAX_TBL = (NUM_INIT > NUM_CHK) ? NUM_INIT : NUM_CHK;
  localparam int IDX_W   = (MAX_TBL > 1) ? $clog2(MAX_TBL) : 1;
  localparam int FF_W    = $clog2(NUM_CHK) + 1;

  logic              cfg_we;
  logic [1:0]        cfg_sel;
  logic [IDX_W-1:0]  cfg_idx;
  logic              cfg_tgt;
  logic [MEM_AW-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              start;
  logic              cpu_rst;
  logic              dm_we;
  logic [MEM_AW-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic [REG_AW-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              busy;
  logic              done;
  logic              pass;
  logic [7:0]        fail_cnt;
  logic [FF_W-1:0]   first_fail;
`ifdef SEQ_WATCH_EN
  logic [DATA_W-1:0] watch_data;
  logic [CYC_W-1:0]  watch_chg;
`endif

  // Sequencer side
  modport slave (
    input  cfg_we, cfg_sel, cfg_idx, cfg_tgt, cfg_addr, cfg_data, start,
    input  dm_rdata, rf_rdata,
`ifdef SEQ_WATCH_EN
    input  watch_data,
    output watch_chg,
`endif
    output cpu_rst, dm_we, dm_addr, dm_wdata, rf_raddr,
    output busy, done, pass, fail_cnt, first_fail
  );

  // Host / datapath side
  modport master (
    output cfg_we, cfg_sel, cfg_idx, cfg_tgt, cfg_addr, cfg_data, start,
    output dm_rdata, rf_rdata,
`ifdef SEQ_WATCH_EN
    output watch_data,
    input  watch_chg,
`endif
    input  cpu_rst, dm_we, dm_addr, dm_wdata, rf_raddr,
    input  busy, done, pass, fail_cnt, first_fail
  );
endinterface

`default_nettype wire

// File: rtl/sc_test_sequencer.sv
// ============================================================================
// Module   : sc_test_sequencer
// Purpose  : Hardware bring-up sequencer for the single-cycle datapath:
//            hold reset + preload dmem, run N cycles, read back and compare
//            dmem/regfile words against an expect table.
// Config   : cfg_sel=2 packs cfg_data as
//            {.., n_init[CNT_I-1:0], n_chk[CNT_C-1:0], run_cyc[CYC_W-1:0]}
//            (LSB first: run_cyc, then n_chk, then n_init).
// Options  : SEQ_WATCH_EN adds a RUN-phase change counter on watch_data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_test_sequencer #(
  parameter int DATA_W   = 32,
  parameter int MEM_AW   = 8,
  parameter int REG_AW   = 5,
  parameter int NUM_INIT = 8,
  parameter int NUM_CHK  = 8,
  parameter int CYC_W    = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  sc_test_sequencer_if.slave bus
);
  localparam int MAX_TBL = (NUM_INIT > NUM_CHK) ? NUM_INIT : NUM_CHK;
  localparam int IDX_W   = (MAX_TBL > 1) ? $clog2(MAX_TBL) : 1;
  localparam int FF_W    = $clog2(NUM_CHK) + 1;
  localparam int CNT_I   = $clog2(NUM_INIT) + 1;
  localparam int CNT_C   = $clog2(NUM_CHK) + 1;
  localparam logic [CYC_W-1:0] ONE = CYC_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_PRELOAD = 3'd2,
    S_RUN     = 3'd3,
    S_CHECK   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state, next_state;

  // Tables (not reset) and sequence counts
  logic [MEM_AW-1:0] init_addr [NUM_INIT];
  logic [DATA_W-1:0] init_data [NUM_INIT];
  logic              chk_tgt   [NUM_CHK];
  logic [MEM_AW-1:0] chk_addr  [NUM_CHK];
  logic [DATA_W-1:0] chk_data  [NUM_CHK];
  logic [CNT_I-1:0]  n_init;
  logic [CNT_C-1:0]  n_chk;
  logic [CYC_W-1:0]  run_cyc;

  logic [CYC_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [CYC_W-1:0]  n_init_w, n_chk_w;
  logic              cmp_vld;
  logic [IDX_W-1:0]  cmp_idx;
  logic [DATA_W-1:0] cmp_obs;
  logic              cmp_bad;
  logic [7:0]        fail_cnt;
  logic [FF_W-1:0]   first_fail;
  logic              idle_or_done;
  logic              start_ok;
  logic              cfg_ok;
  logic [CNT_I-1:0]  cfg_n_init;
  logic [CNT_C-1:0]  cfg_n_chk;

  assign idx          = cnt[IDX_W-1:0];
  assign n_init_w     = CYC_W'(n_init);
  assign n_chk_w      = CYC_W'(n_chk);
  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign start_ok     = bus.start && idle_or_done;
  assign cfg_ok       = bus.cfg_we && idle_or_done;
  assign cfg_n_chk    = bus.cfg_data[CYC_W +: CNT_C];
  assign cfg_n_init   = bus.cfg_data[CYC_W + CNT_C +: CNT_I];
  assign cmp_obs      = chk_tgt[cmp_idx] ? bus.rf_rdata : bus.dm_rdata;
  assign cmp_bad      = cmp_vld && (cmp_obs != chk_data[cmp_idx]);

  assign bus.pass       = (state == S_DONE) && (fail_cnt == 8'd0);
  assign bus.fail_cnt   = fail_cnt;
  assign bus.first_fail = first_fail;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode and per-state datapath/memory controls
  always_comb begin
    next_state   = state;
    bus.cpu_rst  = 1'b1;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    bus.rf_raddr = '0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) next_state = S_HOLD;
      end
      S_HOLD: begin
        bus.busy = 1'b1;
        if (cnt == ONE) begin
          if (n_init != '0)        next_state = S_PRELOAD;
          else if (run_cyc != '0)  next_state = S_RUN;
          else                     next_state = S_CHECK;
        end
      end
      S_PRELOAD: begin
        bus.busy     = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = init_addr[idx];
        bus.dm_wdata = init_data[idx];
        if (cnt == n_init_w - ONE)
          next_state = (run_cyc != '0) ? S_RUN : S_CHECK;
      end
      S_RUN: begin
        // dm_addr held constant at zero while the core owns the memory
        bus.busy    = 1'b1;
        bus.cpu_rst = 1'b0;
        if (cnt == run_cyc - ONE) next_state = S_CHECK;
      end
      S_CHECK: begin
        bus.busy = 1'b1;
        if (cnt < n_chk_w) begin
          bus.dm_addr  = chk_addr[idx];
          bus.rf_raddr = chk_addr[idx][REG_AW-1:0];
        end
        if (cnt == n_chk_w) next_state = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (bus.start) next_state = S_HOLD;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Phase counter: restarts on every state change, so it never wraps
  always_ff @(posedge clk) begin
    if (rst)                       cnt <= '0;
    else if (next_state != state)  cnt <= '0;
    else if (bus.busy)             cnt <= cnt + ONE;
  end

  // One-cycle compare pipeline: read issued now, compared next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_vld <= 1'b0;
      cmp_idx <= '0;
    end else begin
      cmp_vld <= (state == S_CHECK) && (cnt < n_chk_w);
      cmp_idx <= idx;
    end
  end

  // Mismatch accounting; first_fail latches only while no failure is recorded
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      fail_cnt   <= '0;
      first_fail <= '1;
    end else if (cmp_bad) begin
      if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
      if (fail_cnt == 8'd0)  first_fail <= FF_W'(cmp_idx);
    end
  end

  // Sequence counts, clamped to table depth on write
  always_ff @(posedge clk) begin
    if (rst) begin
      n_init  <= '0;
      n_chk   <= '0;
      run_cyc <= '0;
    end else if (cfg_ok && bus.cfg_sel == 2'd2) begin
      n_init  <= (cfg_n_init > CNT_I'(NUM_INIT)) ? CNT_I'(NUM_INIT) : cfg_n_init;
      n_chk   <= (cfg_n_chk  > CNT_C'(NUM_CHK))  ? CNT_C'(NUM_CHK)  : cfg_n_chk;
      run_cyc <= bus.cfg_data[CYC_W-1:0];
    end
  end

  // Table storage survives reset so a test can be re-run after rst
  always_ff @(posedge clk) begin
    if (!rst && cfg_ok) begin
      if (bus.cfg_sel == 2'd0 && int'(bus.cfg_idx) < NUM_INIT) begin
        init_addr[bus.cfg_idx] <= bus.cfg_addr;
        init_data[bus.cfg_idx] <= bus.cfg_data;
      end
      if (bus.cfg_sel == 2'd1 && int'(bus.cfg_idx) < NUM_CHK) begin
        chk_tgt[bus.cfg_idx]  <= bus.cfg_tgt;
        chk_addr[bus.cfg_idx] <= bus.cfg_addr;
        chk_data[bus.cfg_idx] <= bus.cfg_data;
      end
    end
  end

`ifdef SEQ_WATCH_EN
  logic [DATA_W-1:0] watch_prev;
  logic [CYC_W-1:0]  watch_cnt;

  assign bus.watch_chg = watch_cnt;

  // Count RUN cycles where the tapped register differs from the prior cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      watch_prev <= '0;
      watch_cnt  <= '0;
    end else begin
      watch_prev <= bus.watch_data;
      if (start_ok)
        watch_cnt <= '0;
      else if (state == S_RUN && bus.watch_data != watch_prev && watch_cnt != '1)
        watch_cnt <= watch_cnt + ONE;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sc_test_sequencer.sv
// ============================================================================
// Module   : tb_sc_test_sequencer
// Purpose  : Self-checking bench for sc_test_sequencer with dmem/regfile
//            models and a table-level reference of the expected outcome.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_test_sequencer;
  localparam int DATA_W   = 32;
  localparam int MEM_AW   = 8;
  localparam int REG_AW   = 5;
  localparam int NUM_INIT = 8;
  localparam int NUM_CHK  = 8;
  localparam int CYC_W    = 16;
  localparam int FF_NONE  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_test_sequencer_if #(.DATA_W(DATA_W), .MEM_AW(MEM_AW), .REG_AW(REG_AW),
    .NUM_INIT(NUM_INIT), .NUM_CHK(NUM_CHK), .CYC_W(CYC_W)) itf ();

  sc_test_sequencer #(.DATA_W(DATA_W), .MEM_AW(MEM_AW), .REG_AW(REG_AW),
    .NUM_INIT(NUM_INIT), .NUM_CHK(NUM_CHK), .CYC_W(CYC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (itf)
  );

  // Data memory and register file with one-cycle read latency
  logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];
  logic [DATA_W-1:0] rf  [0:(1<<REG_AW)-1];
  always @(posedge clk) begin
    if (itf.dm_we) mem[itf.dm_addr] <= itf.dm_wdata;
    itf.dm_rdata <= mem[itf.dm_addr];
    itf.rf_rdata <= rf[itf.rf_raddr];
  end

  // Observed activity since the last start
  int busy_cnt;
  int run_cnt;
  logic [MEM_AW+DATA_W-1:0] wr_q [$];
  always @(negedge clk) begin
    if (itf.busy) busy_cnt++;
    if (!itf.cpu_rst) run_cnt++;
    if (itf.dm_we) wr_q.push_back({itf.dm_addr, itf.dm_wdata});
  end

  // Shadow of what the bench believes it configured
  logic [MEM_AW-1:0] t_iaddr [NUM_INIT];
  logic [DATA_W-1:0] t_idata [NUM_INIT];
  logic              t_tgt   [NUM_CHK];
  logic [MEM_AW-1:0] t_caddr [NUM_CHK];
  logic [DATA_W-1:0] t_cdata [NUM_CHK];
  int t_ni, t_nc, t_rc;

  // Expected outcome of the run in flight
  int e_ni, e_nc, e_rc, e_fail, e_first;
  logic [MEM_AW+DATA_W-1:0] e_wr [$];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] sel, input int idx, input logic tgt,
                     input logic [MEM_AW-1:0] addr, input logic [DATA_W-1:0] data);
    itf.cfg_we   = 1'b1;
    itf.cfg_sel  = sel;
    itf.cfg_idx  = idx[2:0];
    itf.cfg_tgt  = tgt;
    itf.cfg_addr = addr;
    itf.cfg_data = data;
    tick();
    itf.cfg_we   = 1'b0;
  endtask

  task automatic set_init(input int i, input logic [MEM_AW-1:0] a, input logic [DATA_W-1:0] d);
    cfg(2'd0, i, 1'b0, a, d);
    t_iaddr[i] = a;
    t_idata[i] = d;
  endtask

  task automatic set_chk(input int i, input logic tgt, input logic [MEM_AW-1:0] a,
                         input logic [DATA_W-1:0] d);
    cfg(2'd1, i, tgt, a, d);
    t_tgt[i] = tgt; t_caddr[i] = a; t_cdata[i] = d;
  endtask

  function automatic logic [DATA_W-1:0] pack_counts(input int ni, input int nc, input int rc);
    return DATA_W'({4'(ni), 4'(nc), 16'(rc)});
  endfunction

  task automatic set_counts(input int ni, input int nc, input int rc);
    cfg(2'd2, 0, 1'b0, '0, pack_counts(ni, nc, rc));
    t_ni = ni; t_nc = nc; t_rc = rc;
  endtask

  // What a location should read after the preload, given current memory
  function automatic logic [DATA_W-1:0] ref_value(input logic tgt, input logic [MEM_AW-1:0] a);
    logic [DATA_W-1:0] v;
    int ni;
    if (tgt) return rf[a[REG_AW-1:0]];
    v  = mem[a];
    ni = (t_ni > NUM_INIT) ? NUM_INIT : t_ni;
    for (int i = 0; i < ni; i++)
      if (t_iaddr[i] == a) v = t_idata[i];
    return v;
  endfunction

  task automatic begin_run(input string name);
    e_ni = (t_ni > NUM_INIT) ? NUM_INIT : t_ni;
    e_nc = (t_nc > NUM_CHK)  ? NUM_CHK  : t_nc;
    e_rc = t_rc;
    e_fail = 0;
    e_first = FF_NONE;
    for (int i = 0; i < e_nc; i++)
      if (ref_value(t_tgt[i], t_caddr[i]) !== t_cdata[i]) begin
        if (e_fail == 0) e_first = i;
        e_fail++;
      end
    e_wr.delete();
    for (int i = 0; i < e_ni; i++) e_wr.push_back({t_iaddr[i], t_idata[i]});
    itf.start = 1'b1;
    busy_cnt = 0;
    run_cnt = 0;
    wr_q.delete();
    tick();
    itf.start = 1'b0;
    check({name, " busy after start"}, itf.busy, 1);
    check({name, " done cleared"}, itf.done, 0);
  endtask

  task automatic end_run(input string name);
    int k;
    k = 0;
    while (itf.done !== 1'b1 && k < 3000) begin
      tick();
      k++;
    end
    check({name, " done"}, itf.done, 1);
    check({name, " busy cycles"}, busy_cnt, 2 + e_ni + e_rc + e_nc + 1);
    check({name, " run cycles"}, run_cnt, e_rc);
    check({name, " write count"}, wr_q.size(), e_ni);
    for (int i = 0; i < e_ni && i < wr_q.size(); i++)
      check({name, " write"}, wr_q[i], e_wr[i]);
    check({name, " fail_cnt"}, itf.fail_cnt, e_fail);
    check({name, " first_fail"}, itf.first_fail, e_first);
    check({name, " pass"}, itf.pass, (e_fail == 0));
    check({name, " busy low"}, itf.busy, 0);
  endtask

  initial begin
    int k, seen, ni, nc, rc;
    logic tg;
    logic [MEM_AW-1:0] ad;
    logic [DATA_W-1:0] good;
    itf.cfg_we = 1'b0; itf.cfg_sel = '0; itf.cfg_idx = '0; itf.cfg_tgt = 1'b0;
    itf.cfg_addr = '0; itf.cfg_data = '0; itf.start = 1'b0;
`ifdef SEQ_WATCH_EN
    itf.watch_data = '0;
`endif
    for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = $urandom;
    for (int i = 0; i < (1 << REG_AW); i++) rf[i] = $urandom;
    t_ni = 0; t_nc = 0; t_rc = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst cpu_rst", itf.cpu_rst, 1);
    check("rst dm_we", itf.dm_we, 0);
    check("rst dm_addr", itf.dm_addr, 0);
    check("rst dm_wdata", itf.dm_wdata, 0);
    check("rst rf_raddr", itf.rf_raddr, 0);
    check("rst busy", itf.busy, 0);
    check("rst done", itf.done, 0);
    check("rst pass", itf.pass, 0);
    check("rst fail_cnt", itf.fail_cnt, 0);
    check("rst first_fail", itf.first_fail, FF_NONE);

    // Directed: preload 5 words, run 12, one passing dmem check
    set_init(0, 8'd0, 32'd5);
    set_init(1, 8'd1, 32'd10);
    set_init(2, 8'd2, 32'd20);
    set_init(3, 8'd3, 32'd30);
    set_init(4, 8'd4, 32'd40);
    set_chk(0, 1'b0, 8'd2, 32'd20);
    set_counts(5, 1, 12);
    begin_run("t1");
    end_run("t1");
    check("t1 pass const", itf.pass, 1);

    // Directed: one wrong dmem expectation, one correct regfile check
    set_chk(0, 1'b0, 8'd2, 32'd21);
    set_chk(1, 1'b1, 8'd1, rf[1]);
    set_counts(5, 2, 12);
    begin_run("t2");
    end_run("t2");
    check("t2 fail_cnt const", itf.fail_cnt, 1);
    check("t2 first_fail const", itf.first_fail, 0);

    // Directed: empty sequence, busy for HOLD + one CHECK cycle
    set_counts(0, 0, 0);
    begin_run("t3");
    end_run("t3");

    // Directed: start and config writes during RUN are ignored
    set_counts(5, 2, 12);
    begin_run("t4");
    k = 0;
    while (itf.cpu_rst !== 1'b0 && k < 100) begin tick(); k++; end
    check("t4 reached run", itf.cpu_rst, 0);
    itf.start = 1'b1;
    itf.cfg_we = 1'b1; itf.cfg_sel = 2'd2; itf.cfg_idx = '0;
    itf.cfg_data = pack_counts(1, 1, 3);
    tick();
    itf.start = 1'b0;
    itf.cfg_sel = 2'd0; itf.cfg_addr = 8'hEE; itf.cfg_data = 32'hDEAD_BEEF;
    tick();
    itf.cfg_we = 1'b0;
    end_run("t4");
    begin_run("t4b");
    end_run("t4b");

    // Directed: reset in the middle of PRELOAD
    begin_run("t5");
    k = 0; seen = 0;
    while (k < 50) begin
      if (itf.dm_we) seen++;
      if (seen == 2) break;
      tick();
      k++;
    end
    check("t5 second write", seen, 2);
    rst = 1'b1;
    tick();
    check("t5 cpu_rst", itf.cpu_rst, 1);
    check("t5 dm_we", itf.dm_we, 0);
    check("t5 done", itf.done, 0);
    check("t5 busy", itf.busy, 0);
    rst = 1'b0;
    t_ni = 0; t_nc = 0; t_rc = 0;
    repeat (6) tick();
    check("t5 writes", wr_q.size(), 2);
    check("t5 still idle", itf.busy, 0);

    // Randomized sequences, counts may exceed table depth
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NUM_INIT; i++)
        set_init(i, 8'($urandom_range(0, 15)), $urandom);
      ni = $urandom_range(0, 10);
      nc = $urandom_range(0, 10);
      rc = $urandom_range(0, 20);
      set_counts(ni, nc, rc);
      for (int i = 0; i < NUM_CHK; i++) begin
        tg = 1'($urandom_range(0, 1));
        ad = 8'($urandom_range(0, 31));
        good = ref_value(tg, ad);
        set_chk(i, tg, ad, ($urandom_range(0, 2) == 0) ? $urandom : good);
      end
      begin_run("rnd");
      end_run("rnd");
    end

`ifdef SEQ_WATCH_EN
    // Watch tap: three changes inside a 10-cycle RUN
    set_counts(0, 0, 10);
    begin_run("tw");
    k = 0;
    while (itf.cpu_rst !== 1'b0 && k < 100) begin tick(); k++; end
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 5 || c == 7) itf.watch_data = ~itf.watch_data;
      tick();
    end
    end_run("tw");
    check("tw watch_chg", itf.watch_chg, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
